// File: rtl/pipe_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_pkg
// Shared types and constants for the two-entry pipeline skid stage.
//   occ_t       : 2-bit occupancy count (0..2 held entries)
//   OCC_*       : named occupancy values
//   occ_count() : sums two valid bits into an occupancy value
// -----------------------------------------------------------------------------
package pipe_skid_stage_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    function automatic occ_t occ_count(input logic a, input logic b);
        return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
    endfunction

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One pipeline holding slot: valid bit + payload + control bundle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_load            : capture i_data/i_ctrl and mark the slot valid
//   i_clear           : invalidate the slot (wins over i_load)
//   i_data, i_ctrl    : values to capture
//   o_valid, o_data,
//   o_ctrl            : registered slot contents
// Clearing drops ctrl back to CTRL_IDLE but leaves data untouched, so an
// empty slot shows an idle control bundle with a non-toggling payload.
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 8,
    parameter logic [CTRL_W-1:0] CTRL_IDLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= CTRL_IDLE;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_IDLE;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry valid/ready pipeline register with a skid slot, so in_ready is
// driven purely from a register and never depends on out_ready.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_data, in_ctrl      : upstream payload and control bundle
//   flush                 : synchronous kill of held and incoming entries
//   out_valid/out_ready   : downstream handshake
//   out_data, out_ctrl    : downstream payload and control (CTRL_IDLE when empty)
//   occupancy             : registered count of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 8,
    parameter logic [CTRL_W-1:0] CTRL_IDLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    logic              w_pop;
    logic              w_accept;
    logic              w_main_free;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_next;
    logic              w_skid_next;
    logic [DATA_W-1:0] w_main_d_data;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    occ_t              r_occ;

    assign w_pop       = w_main_valid & out_ready;
    // An accept is impossible while the skid slot holds an entry, which is
    // what keeps skid->main and input->main from ever colliding.
    assign w_accept    = in_valid & ~w_skid_valid;
    assign w_main_free = ~w_main_valid | w_pop;

    // Main refills from skid first (older entry), otherwise from the input.
    assign w_main_load   = ~flush & w_main_free & (w_skid_valid | w_accept);
    assign w_main_clear  = flush | (w_main_free & ~w_skid_valid & ~w_accept);
    assign w_main_d_data = w_skid_valid ? w_skid_data : in_data;
    assign w_main_d_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

    // Skid only catches an entry when main is busy and not draining.
    assign w_skid_load  = w_accept & ~w_main_free;
    assign w_skid_clear = flush | (w_skid_valid & w_main_free);

    assign w_main_next = w_main_free ? (w_skid_valid | w_accept) : 1'b1;
    assign w_skid_next = w_main_free ? 1'b0 : (w_skid_valid | w_accept);

    pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CTRL_IDLE (CTRL_IDLE)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d_data),
        .i_ctrl  (w_main_d_ctrl),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CTRL_IDLE (CTRL_IDLE)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= OCC_EMPTY;
        end else if (flush) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= occ_count(w_main_next, w_skid_next);
        end
    end

    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_ctrl;
    assign occupancy = r_occ;

endmodule
